// File: rtl/freq_sweep.sv
// freq_sweep: timed, stepped frequency sweep that drives the waveform
// generator's freq command in single-ramp or continuous-triangle mode.
module freq_sweep #(
  parameter int unsigned FCLK    = 50000000,
  parameter int unsigned F_START = 100,
  parameter int unsigned F_STOP  = 10000,
  parameter int unsigned F_STEP  = 100,
  parameter int unsigned DWELL   = FCLK / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        mode,
  output logic [31:0] freq,
  output logic        busy,
  output logic        step_strobe,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_e;

  localparam logic [31:0] START_V = 32'(F_START);
  localparam logic [31:0] STOP_V  = 32'(F_STOP);
  localparam logic [31:0] STEP_V  = 32'(F_STEP);
  localparam logic [31:0] D_LAST  = 32'(DWELL - 1);
  localparam logic [32:0] STEP_33 = 33'(F_STEP);
  localparam logic [32:0] STOP_33 = 33'(F_STOP);
  localparam logic [32:0] LOW_33  = 33'(F_START) + 33'(F_STEP);

  state_e      state_q, state_d;
  logic [31:0] freq_q, freq_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic        mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        strobe_q, strobe_d;
  logic        done_q, done_d;

  logic        step;
  logic [32:0] nxt;

  assign step = (dcnt_q == D_LAST);
  assign nxt  = {1'b0, freq_q} + STEP_33;

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    dcnt_d   = dcnt_q;
    mode_d   = mode_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (halt) begin
      state_d = IDLE;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            freq_d  = START_V;
            dcnt_d  = '0;
            mode_d  = mode;
            state_d = RAMP_UP;
          end
        end
        RAMP_UP: begin
          dcnt_d = dcnt_q + 32'd1;
          if (step) begin
            dcnt_d   = '0;
            strobe_d = 1'b1;
            if (nxt >= STOP_33) begin
              freq_d = STOP_V;
              if (mode_q) begin
                state_d = RAMP_DOWN;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              freq_d = nxt[31:0];
            end
          end
        end
        RAMP_DOWN: begin
          dcnt_d = dcnt_q + 32'd1;
          if (step) begin
            dcnt_d   = '0;
            strobe_d = 1'b1;
            // Snap to the floor rather than subtract past it
            if ({1'b0, freq_q} <= LOW_33) begin
              freq_d  = START_V;
              state_d = RAMP_UP;
            end else begin
              freq_d = freq_q - STEP_V;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      freq_q   <= START_V;
      dcnt_q   <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      dcnt_q   <= dcnt_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign freq        = freq_q;
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;

endmodule
